// File: rtl/fetch_pkg.sv
// fetch_pkg: types and widths shared by the fetch-to-decode queue.
//   PC_WIDTH       width of one PC or instruction slot
//   FETCH_WIDTH    slots per fetch bundle
//   fetch_bundle_t one fetch bundle: slot PCs, instructions, recovery PCs
//                  and prediction bits, with slot 0 in the low bits of each field
//   BUNDLE_W       packed width of fetch_bundle_t (196 bits)
package fetch_pkg;

  localparam int PC_WIDTH    = 16;
  localparam int FETCH_WIDTH = 4;

  typedef struct packed {
    logic [FETCH_WIDTH*PC_WIDTH-1:0] pc;
    logic [FETCH_WIDTH*PC_WIDTH-1:0] inst;
    logic [FETCH_WIDTH*PC_WIDTH-1:0] recv_pc;
    logic [FETCH_WIDTH-1:0]          pred;
  } fetch_bundle_t;

  localparam int BUNDLE_W = $bits(fetch_bundle_t);

endpackage

// File: rtl/fdq_storage.sv
// fdq_storage: DEPTH x BUNDLE_W register array for the fetch-to-decode queue.
// One synchronous write port and one asynchronous read port. All entries
// clear to 0 on reset, so the read port shows 0 until something is written.
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        write wr_data into entry wr_addr at the next rising edge
//   wr_addr      write entry index
//   wr_data      bundle to store
//   rd_addr      read entry index
//   rd_data      combinational contents of entry rd_addr
module fdq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fetch_bundle_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output fetch_bundle_t rd_data
);

  fetch_bundle_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular buffer of fetch bundles between fetch and decode.
// Absorbs decode back-pressure, stalls fetch when full and discards all
// buffered bundles in one cycle on a misprediction flush.
//
// Optional feature macro: FDQ_BYPASS_EN. When defined, a bundle arriving at an
// empty queue while decode is ready goes straight to the outputs in the same
// cycle without being written. When undefined there is no combinational path
// from any fetch input to any output.
//
// Handshake: a bundle moves fetch->queue when fetch_vld && !stall_fetch && !flush,
// and queue->decode when out_vld && dec_rdy && !flush. stall_fetch depends
// only on count, never on dec_rdy.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   fetch_vld              fetch presents a bundle
//   pc_from_fet, inst_from_fet, recv_pc_from_fet, pred_result_from_fet  bundle in
//   stall_fetch            queue full, fetch must re-present its bundle
//   dec_rdy                decode takes the head bundle
//   flush                  ROB misprediction, empties the queue
//   out_vld                head bundle valid
//   pc_to_dec, inst_to_dec, recv_pc_to_dec, pred_result_to_dec  head bundle out
//   count                  occupancy (debug / perf)
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = fetch_pkg::PC_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_vld,
  input  logic [4*PC_WIDTH-1:0]         pc_from_fet,
  input  logic [4*PC_WIDTH-1:0]         inst_from_fet,
  input  logic [4*PC_WIDTH-1:0]         recv_pc_from_fet,
  input  logic [3:0]                    pred_result_from_fet,
  output logic                          stall_fetch,
  input  logic                          dec_rdy,
  input  logic                          flush,
  output logic                          out_vld,
  output logic [4*PC_WIDTH-1:0]         pc_to_dec,
  output logic [4*PC_WIDTH-1:0]         inst_to_dec,
  output logic [4*PC_WIDTH-1:0]         recv_pc_to_dec,
  output logic [3:0]                    pred_result_to_dec,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          queued_vld;
  logic          bypass;
  logic          enq;
  logic          deq;
  fetch_bundle_t in_bundle;
  fetch_bundle_t head_bundle;
  fetch_bundle_t out_bundle;

  assign in_bundle.pc      = pc_from_fet;
  assign in_bundle.inst    = inst_from_fet;
  assign in_bundle.recv_pc = recv_pc_from_fet;
  assign in_bundle.pred    = pred_result_from_fet;

  assign full        = (count == CW'(DEPTH));
  assign stall_fetch = full;
  assign queued_vld  = (count != '0);

`ifdef FDQ_BYPASS_EN
  assign bypass = !queued_vld && fetch_vld && dec_rdy && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed bundle is consumed directly by decode and never stored.
  assign enq = fetch_vld && !full && !flush && !bypass;
  // Only stored bundles advance rd_ptr; a bypass happens with count == 0.
  assign deq = queued_vld && dec_rdy && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Pointers only; entry contents are left stale.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  fdq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (enq),
    .wr_addr (wr_ptr),
    .wr_data (in_bundle),
    .rd_addr (rd_ptr),
    .rd_data (head_bundle)
  );

  assign out_bundle = bypass ? in_bundle : head_bundle;
  assign out_vld    = queued_vld || bypass;

  assign pc_to_dec          = out_bundle.pc;
  assign inst_to_dec        = out_bundle.inst;
  assign recv_pc_to_dec     = out_bundle.recv_pc;
  assign pred_result_to_dec = out_bundle.pred;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed and random stimulus for fetch_decode_queue
// with a reference occupancy model and an expected-bundle queue.
// Build with FDQ_BYPASS_EN defined to cover the bypass path.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int PCW   = 16;
  localparam int BW    = 196;

  logic                          clk;
  logic                          rst_n;
  logic                          fetch_vld;
  logic [4*PCW-1:0]              pc_in;
  logic [4*PCW-1:0]              inst_in;
  logic [4*PCW-1:0]              recv_in;
  logic [3:0]                    pred_in;
  logic                          stall_fetch;
  logic                          dec_rdy;
  logic                          flush;
  logic                          out_vld;
  logic [4*PCW-1:0]              pc_to_dec;
  logic [4*PCW-1:0]              inst_to_dec;
  logic [4*PCW-1:0]              recv_pc_to_dec;
  logic [3:0]                    pred_result_to_dec;
  logic [$clog2(DEPTH+1)-1:0]    count;

  int tests;
  int fails;
  int m_count;
  logic [BW-1:0] exp_q[$];

  fetch_decode_queue #(
    .DEPTH    (DEPTH),
    .PC_WIDTH (PCW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .fetch_vld            (fetch_vld),
    .pc_from_fet          (pc_in),
    .inst_from_fet        (inst_in),
    .recv_pc_from_fet     (recv_in),
    .pred_result_from_fet (pred_in),
    .stall_fetch          (stall_fetch),
    .dec_rdy              (dec_rdy),
    .flush                (flush),
    .out_vld              (out_vld),
    .pc_to_dec            (pc_to_dec),
    .inst_to_dec          (inst_to_dec),
    .recv_pc_to_dec       (recv_pc_to_dec),
    .pred_result_to_dec   (pred_result_to_dec),
    .count                (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] cur_bundle();
    return {pc_in, inst_in, recv_in, pred_in};
  endfunction

  function automatic logic [BW-1:0] out_bundle();
    return {pc_to_dec, inst_to_dec, recv_pc_to_dec, pred_result_to_dec};
  endfunction

  // driver: slot i carries PC base+4*i, other fields random
  task automatic set_bundle(input logic [15:0] base);
    for (int i = 0; i < 4; i++) begin
      pc_in[i*PCW +: PCW]   = base + 16'(4*i);
      inst_in[i*PCW +: PCW] = 16'($urandom);
      recv_in[i*PCW +: PCW] = 16'($urandom);
    end
    pred_in = 4'($urandom);
  endtask

  // Checks this cycle's outputs against the model at the falling edge,
  // scores any handshake, then advances the model across the rising edge.
  task automatic tick();
    logic          byp;
    logic          exp_vld;
    logic          enq;
    logic          deq;
    logic [BW-1:0] e;
    @(negedge clk);
    byp = 1'b0;
`ifdef FDQ_BYPASS_EN
    byp = (m_count == 0) && fetch_vld && dec_rdy && !flush;
`endif
    exp_vld = (m_count != 0) || byp;
    chk("out_vld", BW'(out_vld), BW'(exp_vld));
    chk("stall_fetch", BW'(stall_fetch), BW'(m_count == DEPTH));
    chk("count", BW'(count), BW'(m_count));
    if (exp_vld && dec_rdy && !flush) begin
      if (byp) e = cur_bundle();
      else     e = exp_q.pop_front();
      chk("head_bundle", out_bundle(), e);
    end
    if (flush) begin
      m_count = 0;
      exp_q.delete();
    end else begin
      enq = fetch_vld && (m_count < DEPTH) && !byp;
      deq = (m_count != 0) && dec_rdy;
      if (enq) exp_q.push_back(cur_bundle());
      m_count = m_count + int'(enq) - int'(deq);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_count = 0;
    rst_n = 1'b0;
    fetch_vld = 1'b0;
    dec_rdy = 1'b0;
    flush = 1'b0;
    pc_in = '0;
    inst_in = '0;
    recv_in = '0;
    pred_in = '0;

    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_vld", BW'(out_vld), BW'(0));
    chk("rst_stall", BW'(stall_fetch), BW'(0));
    chk("rst_count", BW'(count), BW'(0));
    chk("rst_data", out_bundle(), BW'(0));
    rst_n = 1'b1;

    // fill with decode stalled
    dec_rdy = 1'b0;
    fetch_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_bundle(16'(4*i));
      tick();
    end
    chk("fill_count", BW'(count), BW'(4));
    chk("fill_stall", BW'(stall_fetch), BW'(1));
    set_bundle(16'h0010);
    tick();
    chk("fill_5th_dropped", BW'(count), BW'(4));

    // drain in order
    fetch_vld = 1'b0;
    dec_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", BW'(pc_to_dec[15:0]), BW'(16'(4*i)));
      tick();
      if (i == 0) chk("drain_stall_drop", BW'(stall_fetch), BW'(0));
    end
    chk("drain_empty", BW'(out_vld), BW'(0));

    // full with simultaneous enqueue and dequeue
    dec_rdy = 1'b0;
    fetch_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_bundle(16'h0020 + 16'(4*i));
      tick();
    end
    set_bundle(16'h0030);
    dec_rdy = 1'b1;
    tick();
    chk("full_swap_count1", BW'(count), BW'(3));
    tick();
    chk("full_swap_count2", BW'(count), BW'(3));
    fetch_vld = 1'b0;
    repeat (3) tick();

    // flush drops the queue and the same-cycle fetch bundle
    dec_rdy = 1'b0;
    fetch_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_bundle(16'h0050 + 16'(4*i));
      tick();
    end
    set_bundle(16'h0040);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_vld = 1'b0;
    chk("flush_count", BW'(count), BW'(0));
    chk("flush_out_vld", BW'(out_vld), BW'(0));
    dec_rdy = 1'b1;
    repeat (2) tick();
    dec_rdy = 1'b0;
    fetch_vld = 1'b1;
    set_bundle(16'h0060);
    tick();
    fetch_vld = 1'b0;
    chk("post_flush_pc", BW'(pc_to_dec[15:0]), BW'(16'h0060));
    dec_rdy = 1'b1;
    tick();

`ifdef FDQ_BYPASS_EN
    // bypass on an empty queue
    dec_rdy = 1'b1;
    fetch_vld = 1'b1;
    set_bundle(16'h0100);
    #2;
    chk("bypass_vld", BW'(out_vld), BW'(1));
    chk("bypass_pc", BW'(pc_to_dec[15:0]), BW'(16'h0100));
    tick();
    fetch_vld = 1'b0;
    chk("bypass_count", BW'(count), BW'(0));
`endif

    // random traffic
    for (int c = 0; c < 300; c++) begin
      fetch_vld = 1'($urandom_range(0, 1));
      dec_rdy = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      set_bundle(16'($urandom));
      tick();
    end
    flush = 1'b0;

    // reset asserted mid-traffic clears everything at once
    dec_rdy = 1'b0;
    fetch_vld = 1'b1;
    set_bundle(16'h0200);
    tick();
    set_bundle(16'h0204);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_vld", BW'(out_vld), BW'(0));
    chk("midrst_stall", BW'(stall_fetch), BW'(0));
    chk("midrst_count", BW'(count), BW'(0));
    chk("midrst_data", out_bundle(), BW'(0));
    m_count = 0;
    exp_q.delete();
    fetch_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Decoupling queue between the 4-wide fetch stage and decode. Each entry holds one fetch bundle: four PCs, four instructions, four recovery PCs and four prediction bits. The queue absorbs decode back-pressure, which comes from a full issue queue, and drives `stall_fetch` back to fetch. On a ROB misprediction it discards every buffered bundle in a single cycle.

## Interface
Parameters:
- `DEPTH`, 4: number of bundle entries; power of two, ≥2.
- `PC_WIDTH`, 16: width of one PC/instruction slot.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_vld`  in  1  fetch presents a valid bundle this cycle.
- `pc_from_fet`  in  4*PC_WIDTH  slot PCs, slot 0 in bits [15:0].
- `inst_from_fet`  in  4*PC_WIDTH  slot instructions.
- `recv_pc_from_fet`  in  4*PC_WIDTH  per-slot recovery PCs.
- `pred_result_from_fet`  in  4  per-slot prediction bits.
- `stall_fetch`  out  1  queue full; fetch holds its PC and re-presents the same bundle.
- `dec_rdy`  in  1  decode accepts the head bundle this cycle.
- `flush`  in  1  `has_mispredict` from ROB.
- `out_vld`  out  1  head bundle valid.
- `pc_to_dec`, `inst_to_dec`, `recv_pc_to_dec`  out  4*PC_WIDTH  head bundle fields.
- `pred_result_to_dec`  out  4  head prediction bits.
- `count`  out  $clog2(DEPTH+1)  occupancy, for debug and perf counters.

## Operation
- Circular buffer with registers `wr_ptr`, `rd_ptr` (log2 DEPTH bits, natural wrap) and `count`.
- Enqueue fires when `fetch_vld && !full && !flush`. It writes the entry at `wr_ptr` and increments `wr_ptr`.
- Dequeue fires when `out_vld && dec_rdy && !flush`. It increments `rd_ptr`.
- Count update:
  - enqueue and dequeue in the same cycle: `count` unchanged;
  - enqueue only: `count` +1;
  - dequeue only: `count` −1.
- `full = (count == DEPTH)`; `stall_fetch = full`.
- When full, a simultaneous dequeue frees a slot for the next cycle only. No enqueue happens in the full cycle.
- `out_vld = (count != 0)`. Outputs are read combinationally from the entry at `rd_ptr`. When empty, data outputs hold the stale entry, and decode must qualify them with `out_vld`.
- Flush has priority over everything:
  - `count`, `wr_ptr` and `rd_ptr` go to 0 at the next edge;
  - the bundle on the fetch inputs that cycle is dropped;
  - `out_vld` is still driven normally during the flush cycle, but no dequeue is counted.
- Entry data is never cleared on flush; only the pointers reset.

## Timing
- Reset (async, `rst_n` = 0):
  - `count`, `wr_ptr`, `rd_ptr` = 0;
  - all entry registers = 0;
  - `out_vld` = 0, `stall_fetch` = 0, all data outputs = 0.
- Latency from enqueue to `out_vld` is 1 cycle when the queue is empty, in the non-bypass build.
- Throughput is one bundle per cycle in steady state.
- `stall_fetch` deasserts the cycle after a dequeue from a full queue.
- `stall_fetch` depends on `count` only, so there is no combinational path from `dec_rdy` to `stall_fetch`.
- After a flush, the first new bundle can be enqueued in the following cycle.
- Reset asserted mid-operation: state clears immediately and asynchronously; no partial bundle survives.

## Configuration
- `FDQ_BYPASS_EN` defined:
  - when `count == 0`, `fetch_vld`, `dec_rdy` and `!flush` all hold, the fetch bundle drives the outputs combinationally with `out_vld` = 1;
  - the bundle is not written and `count` stays 0;
  - if `dec_rdy` = 0, the bundle is enqueued normally.
- `FDQ_BYPASS_EN` undefined: always 1-cycle latency. There is no combinational path from any fetch input to any output.

## Structure
- Shared package `fetch_pkg` holds:
  - `PC_WIDTH` and `FETCH_WIDTH` = 4;
  - `fetch_bundle_t` struct (pc, inst, recv_pc, pred) together with `BUNDLE_W` = 196.
- One sub-module, `fdq_storage`: a DEPTH × BUNDLE_W register array with one write port and one asynchronous read port, reset to 0.
- Pointer, count and flush logic live in the top module.

## Test plan
- Reset: drive `rst_n` = 0 mid-traffic → `out_vld` = 0, `stall_fetch` = 0, `count` = 0 immediately; all outputs 0.
- Fill: `dec_rdy` = 0, present 4 bundles with PC 0x0000, 0x0004, 0x0008, 0x000C.
  - `count` = 4 and `stall_fetch` = 1 after the 4th edge;
  - a 5th bundle (0x0010) is not written.
- Drain order: then `dec_rdy` = 1 → `pc_to_dec` is 0x0000, 0x0004, 0x0008, 0x000C on consecutive cycles; `stall_fetch` drops after the first dequeue.
- Full with simultaneous enqueue and dequeue: queue full, `fetch_vld` = 1, `dec_rdy` = 1.
  - `count` goes 4 → 3, and the new bundle is not taken;
  - next cycle the new bundle is enqueued and `count` stays 3.
- Flush: 3 entries, `flush` = 1 with `fetch_vld` = 1 (PC 0x0040).
  - next cycle `count` = 0 and `out_vld` = 0;
  - 0x0040 is never seen on the outputs.
- Bypass, only with `FDQ_BYPASS_EN`: empty queue, `dec_rdy` = 1, bundle PC 0x0100 → same-cycle `out_vld` = 1 and `pc_to_dec[15:0]` = 0x0100; `count` stays 0.
